clk_frac_div_ctrl: RTL

//  Run-time controller for the phase-accumulator fractional clock divider, with the accumulator included.
//  - Accepts a divide ratio in unsigned fixed point (Q(DIV_W-FRAC_W).FRAC_W) over a valid/ready handshake.
//  - Computes the accumulator step iteratively and applies it only at an accumulator wrap, so clk_out never glitches.
//  - Also provides glitch-free start/stop of clk_out.

---
 rtl/clk_frac_div_ctrl_if.sv | 19 +
 rtl/clk_frac_div_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/clk_frac_div_ctrl_if.sv
// clk_frac_div_ctrl_if: ratio-configuration bus of the fractional clock divider.
//   cfg_valid/cfg_div : source offers a divide ratio (unsigned fixed point)
//   cfg_ready         : controller can accept a ratio
//   cfg_err           : one-cycle pulse, offered ratio rejected
//   upd_done          : one-cycle pulse, new step now in effect
//   cur_step          : step currently used by the accumulator
interface clk_frac_div_ctrl_if #(
  parameter int DIV_W = 16,
  parameter int ACC_W = 16
);
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             upd_done;
  logic [ACC_W-1:0] cur_step;
  modport master (output cfg_valid, cfg_div, input cfg_ready, cfg_err, upd_done, cur_step);
  modport slave  (input cfg_valid, cfg_div, output cfg_ready, cfg_err, upd_done, cur_step);
endinterface

// File: rtl/clk_frac_div_ctrl.sv
// clk_frac_div_ctrl: phase-accumulator fractional clock divider with run-time ratio control.
//   clk_in    : clock
//   rst_n     : synchronous active-low reset
//   i_run     : 1 = accumulate, 0 = stop at the next wrap
//   cfg       : ratio configuration bus (slave side)
//   o_clk_out : divided clock, MSB of the accumulator
module clk_frac_div_ctrl #(
  parameter int ACC_W        = 16,
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 8,
  parameter int DEFAULT_STEP = 7568
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 i_run,
  clk_frac_div_ctrl_if.slave   cfg,
  output logic                 o_clk_out
);
  localparam int Q_W   = ACC_W + FRAC_W + 1;
  localparam int CNT_W = $clog2(Q_W);
  typedef enum logic [1:0] {IDLE, CALC, PEND} state_t;
  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_step;
  logic [ACC_W-1:0] r_pend;
  logic [ACC_W-1:0] r_q;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W:0]   r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_err;
  logic             r_upd_arm;
  logic             r_upd;
  logic [ACC_W:0]   w_sum;
  logic             w_halt;
  logic             w_wrap;
  logic             w_xfer;
  logic             w_small;
  logic [DIV_W:0]   w_sh;
  logic [DIV_W:0]   w_sub;
  logic             w_ge;
  logic [ACC_W:0]   w_q;
  assign w_sum   = {1'b0, r_acc} + {1'b0, r_step};
  // Stopped: run low and the accumulator already parked at zero.
  assign w_halt  = !i_run && (r_acc == '0);
  assign w_wrap  = !w_halt && w_sum[ACC_W];
  assign w_xfer  = cfg.cfg_valid && r_ready;
  assign w_small = cfg.cfg_div < DIV_W'(1 << (FRAC_W + 1));
  // Restoring division of 2^Q_W: the leading dividend one is preloaded into
  // the remainder, so each cycle shifts in a zero and yields one quotient bit.
  assign w_sh    = r_rem << 1;
  assign w_sub   = w_sh - {1'b0, r_div};
  assign w_ge    = w_sh >= {1'b0, r_div};
  assign w_q     = {r_q, w_ge};
  assign o_clk_out     = r_acc[ACC_W-1];
  assign cfg.cfg_ready = r_ready;
  assign cfg.cfg_err   = r_err;
  assign cfg.upd_done  = r_upd;
  assign cfg.cur_step  = r_step;
  always_ff @(posedge clk_in) begin
    if (!rst_n)
      r_acc <= '0;
    else if (!w_halt)
      r_acc <= (!i_run && w_wrap) ? '0 : w_sum[ACC_W-1:0];
  end
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ready   <= 1'b1;
      r_err     <= 1'b0;
      r_upd_arm <= 1'b0;
      r_upd     <= 1'b0;
      r_step    <= ACC_W'(DEFAULT_STEP);
      r_pend    <= '0;
      r_q       <= '0;
      r_div     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
    end else begin
      r_err     <= w_xfer && w_small;
      r_upd_arm <= 1'b0;
      r_upd     <= r_upd_arm;
      if (r_state == IDLE && w_xfer && !w_small) begin
        r_state <= CALC;
        r_ready <= 1'b0;
        r_div   <= cfg.cfg_div;
        r_rem   <= (DIV_W + 1)'(1);
        r_q     <= '0;
        r_cnt   <= '0;
      end else if (r_state == CALC) begin
        r_rem <= w_ge ? w_sub : w_sh;
        r_q   <= w_q[ACC_W-1:0];
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CNT_W'(Q_W - 1)) begin
          r_state <= PEND;
          r_pend  <= ACC_W'((w_q + 1'b1) >> 1);
        end
      end else if (r_state == PEND && (w_wrap || w_halt)) begin
        // Swap only at a wrap (or while parked) so clk_out never glitches.
        r_step    <= r_pend;
        r_upd_arm <= 1'b1;
        r_state   <= IDLE;
        r_ready   <= 1'b1;
      end
    end
  end
endmodule
